// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: shared pointer-wrap increment used by the FIFO blocks
package fifo_write_arbiter_pkg;
  function automatic logic [31:0] wrap_inc(input logic [31:0] p, input logic [31:0] lim);
    return (p == lim - 32'd1) ? 32'd0 : p + 32'd1;
  endfunction
endpackage

// File: rtl/fifo_write_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick; req/prio in, one-hot gnt and winner idx out (nearest requester at or after prio wins)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   prio,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  int best, d;
  always_comb begin
    best = NUM_REQ;
    d = 0;
    idx = '0;
    gnt = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j >= int'(prio)) ? j - int'(prio) : j + NUM_REQ - int'(prio);
      if (req[j] && d < best) begin
        best = d;
        idx = IDX_W'(j);
      end
    end
    gnt[idx] = |req;
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin push arbiter + pointer/count control for an external shared FIFO array; req/req_data/rd_en in, grant/rd_ack/mem_*/count/full/empty out (all registered)
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          rd_en,
  output logic                          rd_ack,
  output logic                          mem_we,
  output logic [$clog2(DEPTH)-1:0]      mem_waddr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [$clog2(DEPTH)-1:0]      mem_raddr,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0] win, prio;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt_nxt;
  logic [DATA_WIDTH-1:0] wsel;
  logic push, pop;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req(req),
    .prio(prio),
    .gnt(gnt),
    .idx(win)
  );
  // full/empty are registered from cnt_nxt, so they are exact for this cycle's accept decisions
  always_comb begin
    push = |req && !full;
    pop = rd_en && !empty;
    cnt_nxt = count + CNT_W'(push) - CNT_W'(pop);
    wsel = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (win == IDX_W'(j)) wsel = req_data[j*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      rd_ack <= 1'b0;
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_raddr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      prio <= '0;
    end else begin
      grant <= push ? gnt : '0;
      mem_we <= push;
      rd_ack <= pop;
      count <= cnt_nxt;
      full <= cnt_nxt == CNT_W'(DEPTH);
      empty <= cnt_nxt == '0;
      if (push) begin
        mem_waddr <= wr_ptr;
        mem_wdata <= wsel;
        wr_ptr <= ADDR_W'(wrap_inc(32'(wr_ptr), DEPTH));
        prio <= IDX_W'(wrap_inc(32'(win), NUM_REQ));
      end
      if (pop) begin
        mem_raddr <= rd_ptr;
        rd_ptr <= ADDR_W'(wrap_inc(32'(rd_ptr), DEPTH));
      end
    end
  end
endmodule
